// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types, default sizes and helpers for the round-robin burst arbiter.
package rr_burst_arbiter_pkg;

  localparam int unsigned NUM_REQS_DEF    = 4;
  localparam int unsigned MAX_BURST_DEF   = 8;
  localparam int unsigned IDX_WIDTH_DEF   = $clog2(NUM_REQS_DEF);
  localparam int unsigned BURST_WIDTH_DEF = $clog2(MAX_BURST_DEF + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Binary index of the set bit of a one-hot vector (0 when none set); up to 32 requesters.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Rotating find-first: picks the first set request after base, wrapping, with base itself last.
module rr_burst_arbiter_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  pick,
  output logic          found
);

  logic [IW-1:0] idx;

  // Scan offsets 1..N from base so the previous owner gets lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = IW'((32'(base) + off) % N);
      if (!found && reqs[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that holds a winner for up to burst_len beats before rotating.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS    = NUM_REQS_DEF,
  parameter int unsigned MAX_BURST   = MAX_BURST_DEF,
  parameter int unsigned BURST_WIDTH = $clog2(MAX_BURST + 1),
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_REQS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQS-1:0]    reqs,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic [NUM_REQS-1:0]    gnt,
  output logic [IDX_WIDTH-1:0]   gnt_idx,
  output logic                   gnt_vld,
  output logic                   burst_last,
  output logic                   busy
);

  arb_state_t             state_q, state_d;
  logic [IDX_WIDTH-1:0]   owner_q, owner_d;
  logic [BURST_WIDTH-1:0] remain_q, remain_d;

  logic [NUM_REQS-1:0]    pick;
  logic                   found;
  logic [BURST_WIDTH-1:0] eff_len;
  logic                   cont;

  rr_burst_arbiter_pick #(
    .N  (NUM_REQS),
    .IW (IDX_WIDTH)
  ) u_pick (
    .reqs  (reqs),
    .base  (owner_q),
    .pick  (pick),
    .found (found)
  );

  // Zero-length bursts behave as single beats; oversize bursts clamp to MAX_BURST.
  always_comb begin
    eff_len = burst_len;
    if (burst_len == '0) begin
      eff_len = BURST_WIDTH'(1);
    end else if (burst_len > BURST_WIDTH'(MAX_BURST)) begin
      eff_len = BURST_WIDTH'(MAX_BURST);
    end
  end

  // Grant selection and next-state: continue the owner's burst, else re-arbitrate from owner+1.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    remain_d   = remain_q;
    gnt        = '0;
    burst_last = 1'b0;
    cont       = (state_q == BURST) && reqs[owner_q];

    if (!rst) begin
      if (cont) begin
        gnt[owner_q] = 1'b1;
        remain_d     = remain_q - BURST_WIDTH'(1);
        if (remain_q == BURST_WIDTH'(1)) begin
          burst_last = 1'b1;
          state_d    = IDLE;
        end
      end else if (found) begin
        gnt     = pick;
        owner_d = IDX_WIDTH'(onehot_to_idx(32'(pick)));
        if (eff_len == BURST_WIDTH'(1)) begin
          burst_last = 1'b1;
          state_d    = IDLE;
          remain_d   = '0;
        end else begin
          state_d  = BURST;
          remain_d = eff_len - BURST_WIDTH'(1);
        end
      end else begin
        state_d  = IDLE;
        remain_d = '0;
      end
    end
  end

  // Derived grant outputs; busy reflects the registered burst state, masked while in reset.
  always_comb begin
    gnt_idx = IDX_WIDTH'(onehot_to_idx(32'(gnt)));
    gnt_vld = |gnt;
    busy    = (state_q == BURST) && !rst;
  end

  // State registers; reset leaves the last index as owner so index 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= IDX_WIDTH'(NUM_REQS - 1);
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      remain_q <= remain_d;
    end
  end

`ifdef FORMAL
  // Grant safety properties: one-hot-or-zero, only to requesters, never idle with requests.
  always_comb begin
    if (!rst) begin
      assert ((gnt & (gnt - NUM_REQS'(1))) == '0);
      assert ((gnt & ~reqs) == '0);
      assert ((reqs == '0) || (gnt != '0));
    end
  end
`endif

endmodule
